// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, runs one outstanding imem read at a
// time and holds each fetched word for decode; redirects discard wrong-path data.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic               misalign_err
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic         kill;
  logic [31:0]  target_aligned;

  assign target_aligned = word_align(redirect_target);

  // Memory-side outputs depend only on registers, never on same-cycle inputs.
  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect && (redirect_target[1:0] != 2'b00);

      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) fetch_pc <= target_aligned;
        end

        REQ: begin
          if (redirect) begin
            fetch_pc <= target_aligned;
            // A grant in the redirect cycle belongs to the old path: mark it for discard.
            if (imem_gnt) begin
              state <= WAIT;
              kill  <= 1'b1;
            end
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect) begin
            fetch_pc <= target_aligned;
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              instr       <= imem_rdata;
              pc          <= fetch_pc;
              instr_valid <= 1'b1;
              fetch_pc    <= fetch_pc + 32'd4;
              state       <= HOLD;
            end
          end
        end

        HOLD: begin
          // A redirect flushes the held word even if decode accepts it this cycle.
          if (redirect) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            fetch_pc    <= target_aligned;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            state       <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model pushes expected words when it
// answers a live request; they are popped and compared when instr_valid rises.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign_err;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // memory / reference model state
  logic [31:0] exp_fetch;
  logic [31:0] paddr;
  int          pend;
  int          lat;
  logic        killed;
  logic        gnt_en;
  logic        gnt_last;
  logic        deliver_prev;
  logic        prev_valid;
  logic        exp_mis;
  logic        chk_nop_next;
  logic        chk_accept_next;
  logic [31:0] held_instr;
  logic [31:0] held_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: check what the last posedge produced, answer memory, drive inputs.
  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy);
    exp_t e;
    chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (!prev_valid) chk("valid_latency", 32'(instr_valid), 32'(deliver_prev));
    if (chk_accept_next) begin
      chk("req_after_accept", 32'(imem_req), 32'd1);
      chk("valid_after_accept", 32'(instr_valid), 32'd0);
    end
    if (chk_nop_next) begin
      chk("flush_valid", 32'(instr_valid), 32'd0);
      chk("flush_nop", instr, NOP_INSTR);
    end
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_instr", 32'(instr_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("pc", pc, e.pc);
        chk("instr", instr, e.instr);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        $display("instr pc=%08h data=%08h pc_plus4=%08h", pc, instr, pc_plus4);
      end
      held_instr = instr;
      held_pc    = pc;
    end else if (instr_valid) begin
      chk("hold_instr", instr, held_instr);
      chk("hold_pc", pc, held_pc);
      chk("req_in_hold", 32'(imem_req), 32'd0);
    end
    prev_valid = instr_valid;

    deliver_prev = 1'b0;
    gnt_last     = 1'b0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    if (pend > 0) begin
      pend--;
      if (rd) killed = 1'b1;
      if (pend == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = paddr ^ 32'hA5A5_0000;
        if (!killed) begin
          sb_q.push_back('{pc: paddr, instr: paddr ^ 32'hA5A5_0000});
          exp_fetch    = paddr + 32'd4;
          deliver_prev = 1'b1;
        end
      end
    end else if (imem_req && gnt_en) begin
      chk("imem_addr", imem_addr, exp_fetch);
      imem_gnt = 1'b1;
      gnt_last = 1'b1;
      paddr    = exp_fetch;
      pend     = (lat > 0) ? lat : int'($urandom_range(1, 3));
      killed   = rd;
    end
    if (rd) exp_fetch = {tgt[31:2], 2'b00};

    redirect        = rd;
    redirect_target = tgt;
    instr_ready     = rdy;
    exp_mis         = rd && (tgt[1:0] != 2'b00);
    chk_nop_next    = rd && instr_valid;
    chk_accept_next = !rd && rdy && instr_valid;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (deliver_prev) void'(sb_q.pop_back());
    if (pend > 0) killed = 1'b1;
    exp_fetch       = 32'h0;
    deliver_prev    = 1'b0;
    prev_valid      = 1'b0;
    exp_mis         = 1'b0;
    chk_nop_next    = 1'b0;
    chk_accept_next = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input logic rdy);
    for (int k = 0; k < 40 && !instr_valid; k++) step(1'b0, 32'h0, rdy);
    chk("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_gnt();
    gnt_last = 1'b0;
    for (int k = 0; k < 40 && !gnt_last; k++) step(1'b0, 32'h0, 1'b1);
    chk("wait_gnt", 32'(gnt_last), 32'd1);
  endtask

  task automatic wait_req_free();
    for (int k = 0; k < 40 && !(imem_req && pend == 0); k++) step(1'b0, 32'h0, 1'b1);
    chk("wait_req", 32'(imem_req), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_target = 32'h0; instr_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    exp_fetch = 32'h0; paddr = 32'h0; pend = 0; lat = 1; killed = 1'b0;
    gnt_en = 1'b1; gnt_last = 1'b0; deliver_prev = 1'b0; prev_valid = 1'b0;
    exp_mis = 1'b0; chk_nop_next = 1'b0; chk_accept_next = 1'b0;
    held_instr = 32'h0; held_pc = 32'h0;
    @(negedge clk);
    do_reset();

    // Sequential fetch 0,4,8,... at L=1 with decode always ready
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Decode stall for 5 cycles in HOLD
    wait_valid(1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Redirect while waiting; response arrives 3 cycles later and must be dropped
    lat = 4;
    wait_gnt();
    step(1'b1, 32'h0000_0100, 1'b1);
    lat = 1;
    repeat (10) step(1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as the grant
    wait_req_free();
    step(1'b1, 32'h0000_0040, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Misaligned target
    wait_req_free();
    step(1'b1, 32'h0000_0203, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects, then PC wrap at the top of the address space
    step(1'b1, 32'h0000_0500, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Redirect in HOLD with decode ready in the same cycle
    wait_valid(1'b0);
    step(1'b1, 32'h0000_0300, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);

    // Reset in the middle of an outstanding read; late response must be ignored
    lat = 4;
    wait_gnt();
    step(1'b0, 32'h0, 1'b1);
    do_reset();
    lat = 1;
    repeat (14) step(1'b0, 32'h0, 1'b1);

    // Random traffic: grant stalls, variable latency, decode back-pressure, redirects
    lat = 0;
    for (int i = 0; i < 500; i++) begin
      logic        rd;
      logic [31:0] tgt;
      gnt_en = ($urandom_range(0, 3) != 0);
      rd     = ($urandom_range(0, 11) == 0);
      tgt    = {$urandom_range(0, 32'hFFFF) << 2};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step(rd, tgt, ($urandom_range(0, 9) < 7));
    end

    // Drain: no new grants, let any outstanding word be consumed
    gnt_en = 1'b0;
    repeat (10) step(1'b0, 32'h0, 1'b1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
